// File: rtl/assert_change_window_ctrl_pkg.sv
// ============================================================================
// assert_change_window_ctrl_pkg
// ----------------------------------------------------------------------------
// Purpose : shared definitions for the assert_change window sequencer.
//           Holds the new-start policy codes and the state encoding of the
//           window FSM, plus a constant clog2 helper used to size the
//           window counter.
// Ports   : none (package)
// ============================================================================
package assert_change_window_ctrl_pkg;

    // What to do when start_event arrives while a window is already open
    localparam int OVL_IGNORE_NEW_START   = 0;
    localparam int OVL_RESET_ON_NEW_START = 1;
    localparam int OVL_ERROR_ON_NEW_START = 2;

    // Window FSM states
    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } win_state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/assert_change_window_ctrl_counter.sv
// ============================================================================
// ovl_window_counter
// ----------------------------------------------------------------------------
// Purpose : cycle counter for the open window. Clears to zero, increments on
//           request and flags the terminal count.
// Ports   : clk         in  rising-edge clock
//           reset_n     in  asynchronous active-low reset
//           clear       in  load zero (has priority over inc)
//           inc         in  increment by one
//           cnt         out current count
//           at_terminal out cnt equals TERMINAL
// ============================================================================
module ovl_window_counter #(
    parameter int CNT_W    = 2,
    parameter int TERMINAL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_terminal
);

    // Count register: clear wins so a restart or close never lets the
    // count run past the terminal value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_terminal = (cnt == CNT_W'(TERMINAL));

endmodule

// File: rtl/assert_change_window_ctrl.sv
// ============================================================================
// assert_change_window_ctrl
// ----------------------------------------------------------------------------
// Purpose : window sequencer for the assert_change checker. Opens a
//           num_cks-cycle window on start_event, applies the new-start
//           policy, tracks whether test_expr changed inside the window and
//           produces registered window / fire pulses.
// Ports   : clk            in  checker clock, rising edge
//           reset_n        in  asynchronous active-low reset
//           start_event    in  window trigger
//           test_expr      in  [width] expression that must change
//           window         out window open (registered state)
//           window_close   out last open cycle
//           fire_change    out pulse: window closed without a change
//           fire_new_start out pulse: start_event inside window (ERROR mode)
//           cover_window_open/reset/close  out  only with OVL_CHANGE_COVER_EN
// Config  : define OVL_CHANGE_COVER_EN to add the cover_* outputs.
// ============================================================================
module assert_change_window_ctrl
    import assert_change_window_ctrl_pkg::*;
#(
    parameter int width               = 8,
    parameter int num_cks             = 2,
    parameter int action_on_new_start = OVL_IGNORE_NEW_START
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_event,
    input  logic [width-1:0] test_expr,
    output logic             window,
    output logic             window_close,
    output logic             fire_change,
`ifdef OVL_CHANGE_COVER_EN
    output logic             cover_window_open,
    output logic             cover_window_reset,
    output logic             cover_window_close,
`endif
    output logic             fire_new_start
);

    localparam int CNT_W = clog2(num_cks) + 1;

    win_state_t       state, state_nxt;
    logic [width-1:0] prev;
    logic             changed, changed_nxt, diff;
    logic [CNT_W-1:0] cnt;
    logic             at_term;
    logic             opening, restart, closing, new_start_err;
    logic             cnt_clear, cnt_inc;

    ovl_window_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (num_cks - 1)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (cnt_clear),
        .inc         (cnt_inc),
        .cnt         (cnt),
        .at_terminal (at_term)
    );

    assign window       = (state == OPEN);
    assign window_close = (state == OPEN) && at_term;

    // Next-state and control decode. An X/Z compare makes the if-condition
    // unknown, which falls to the else branch, so unknowns count as
    // not-changed. A RESET-mode restart beats the close so a start on the
    // closing edge keeps the window open.
    always_comb begin
        state_nxt     = state;
        opening       = 1'b0;
        restart       = 1'b0;
        closing       = 1'b0;
        new_start_err = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
        changed_nxt   = changed;
        if (test_expr != prev) begin
            diff = 1'b1;
        end else begin
            diff = 1'b0;
        end
        case (state)
            IDLE: begin
                if (start_event) begin
                    state_nxt = OPEN;
                    opening   = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            OPEN: begin
                changed_nxt = changed | diff;
                if (start_event && (action_on_new_start == OVL_RESET_ON_NEW_START)) begin
                    restart   = 1'b1;
                    cnt_clear = 1'b1;
                end else if (at_term) begin
                    closing   = 1'b1;
                    state_nxt = IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (start_event && (action_on_new_start == OVL_ERROR_ON_NEW_START)) begin
                    new_start_err = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Change tracking and registered fire pulses. prev follows test_expr
    // every open cycle so each edge compares against the previous sample;
    // changed is sticky until the window closes or restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev           <= '0;
            changed        <= 1'b0;
            fire_change    <= 1'b0;
            fire_new_start <= 1'b0;
        end else begin
            fire_change    <= closing & ~changed_nxt;
            fire_new_start <= new_start_err;
            if (opening || restart) begin
                prev    <= test_expr;
                changed <= 1'b0;
            end else if (state == OPEN) begin
                prev    <= test_expr;
                changed <= closing ? 1'b0 : changed_nxt;
            end
        end
    end

`ifdef OVL_CHANGE_COVER_EN
    // Cover pulses, registered one cycle after the event they mark
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cover_window_open  <= 1'b0;
            cover_window_reset <= 1'b0;
            cover_window_close <= 1'b0;
        end else begin
            cover_window_open  <= opening;
            cover_window_reset <= restart;
            cover_window_close <= window_close;
        end
    end
`endif

endmodule
